// File: rtl/mem_access.sv
// mem_access: memory stage of the pipeline. Takes one uop from execute,
// passes ALU results straight to writeback, and runs loads/stores over a
// simple request/grant data-memory bus. Misaligned or illegal memory uops
// are not sent to the bus; they retire with wb_exc set.
//
// Handshakes:
//   upstream : a uop is taken only when exe_valid=1, system_stall=0 and the
//              stage is IDLE (mem_stall=0). While mem_stall=1 the upstream
//              stage must hold its uop.
//   bus      : dmem_req rises the cycle after capture and stays high, with
//              dmem_we/addr/be/wdata stable, up to and including the cycle
//              dmem_gnt=1. Read data is taken on the first dmem_rvalid=1
//              seen in WAIT; rvalid in any other state is ignored.
//   writeback: wb_valid is a one-cycle registered pulse; wb_data and
//              wb_rd_addr keep their last values while wb_valid=0.
module mem_access #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_stall,
    input  logic                  exe_valid,
    input  logic                  uop_is_mem,
    input  logic                  mem_is_store,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] Execution_Result,
    input  logic [ADDR_WIDTH-1:0] Mem_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd_addr,
    input  logic                  rd_wr_en,
    output logic                  mem_stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd_addr,
    output logic                  wb_rd_wr_en,
    output logic                  wb_exc,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured memory uop (held for the whole bus transaction)
    logic       is_store_q;
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;
    logic [4:0] rd_addr_q;
    logic       rd_wr_en_q;
    logic [3:0] be_q;

    // Decode of the incoming uop
    logic                  accept;
    logic                  f3_legal;
    logic                  misaligned;
    logic                  mem_ok;
    logic                  mem_bad;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;

    // Load return path
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_val;

    assign accept    = (state == ST_IDLE) && exe_valid && !system_stall;
    assign mem_ok    = uop_is_mem && f3_legal && !misaligned;
    assign mem_bad   = uop_is_mem && !(f3_legal && !misaligned);
    assign state_dbg = state;

    // Access legality and alignment of the incoming uop
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !mem_is_store;
            default:                f3_legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   misaligned = Mem_addr[0];
            2'b10:   misaligned = (Mem_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming uop
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << Mem_addr[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << Mem_addr[1:0];
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        lane     = dmem_rdata >> {addr_lo_q, 3'b000};
        load_val = lane;
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and state-derived bus/stall outputs
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (accept && mem_ok) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = is_store_q;
                dmem_be   = be_q;
                if (dmem_gnt) begin
                    state_next = is_store_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture a legal memory uop and its bus address/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            rd_addr_q  <= 5'd0;
            rd_wr_en_q <= 1'b0;
            be_q       <= 4'b0000;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (accept && mem_ok) begin
            is_store_q <= mem_is_store;
            funct3_q   <= funct3;
            addr_lo_q  <= Mem_addr[1:0];
            rd_addr_q  <= rd_addr;
            rd_wr_en_q <= rd_wr_en && !mem_is_store;
            be_q       <= be_calc;
            dmem_addr  <= {Mem_addr[ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata <= mem_is_store ? wdata_calc : '0;
        end
    end

    // Registered writeback: ALU pass-through, exceptions, store and load retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd_addr  <= 5'd0;
            wb_rd_wr_en <= 1'b0;
            wb_exc      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && !uop_is_mem) begin
                wb_valid    <= 1'b1;
                wb_data     <= Execution_Result;
                wb_rd_addr  <= rd_addr;
                wb_rd_wr_en <= rd_wr_en && (rd_addr != 5'd0);
                wb_exc      <= 1'b0;
            end else if (accept && mem_bad) begin
                // Faulting address is reported in wb_data
                wb_valid    <= 1'b1;
                wb_data     <= Mem_addr;
                wb_rd_addr  <= rd_addr;
                wb_rd_wr_en <= 1'b0;
                wb_exc      <= 1'b1;
            end else if (state == ST_REQ && dmem_gnt && is_store_q) begin
                // Stores retire on grant; the word address is reported as data
                wb_valid    <= 1'b1;
                wb_data     <= dmem_addr;
                wb_rd_addr  <= rd_addr_q;
                wb_rd_wr_en <= 1'b0;
                wb_exc      <= 1'b0;
            end else if (state == ST_WAIT && dmem_rvalid) begin
                wb_valid    <= 1'b1;
                wb_data     <= load_val;
                wb_rd_addr  <= rd_addr_q;
                wb_rd_wr_en <= rd_wr_en_q && (rd_addr_q != 5'd0);
                wb_exc      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors for single-cycle retire paths, hand-written
// bus sequences, and randomized uops checked against a behavioural model.
module tb_mem_access;

    logic        clk;
    logic        reset;
    logic        system_stall;
    logic        exe_valid;
    logic        uop_is_mem;
    logic        mem_is_store;
    logic [2:0]  funct3;
    logic [31:0] Execution_Result;
    logic [31:0] Mem_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_wr_en;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wr_en;
    logic        wb_exc;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;

    mem_access dut (
        .clk              (clk),
        .reset            (reset),
        .system_stall     (system_stall),
        .exe_valid        (exe_valid),
        .uop_is_mem       (uop_is_mem),
        .mem_is_store     (mem_is_store),
        .funct3           (funct3),
        .Execution_Result (Execution_Result),
        .Mem_addr         (Mem_addr),
        .store_data       (store_data),
        .rd_addr          (rd_addr),
        .rd_wr_en         (rd_wr_en),
        .mem_stall        (mem_stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .wb_valid         (wb_valid),
        .wb_data          (wb_data),
        .wb_rd_addr       (wb_rd_addr),
        .wb_rd_wr_en      (wb_rd_wr_en),
        .wb_exc           (wb_exc),
        .state_dbg        (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        sz   = m_size(f3);
        v    = rdata >> (8 * (a % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver: one uop end to end ----------------
    task automatic do_uop(input bit is_mem, input bit is_store, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input bit rwe,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        bit ok;
        bit exp_wr;
        @(negedge clk);
        exe_valid        = 1'b1;
        system_stall     = 1'b0;
        uop_is_mem       = is_mem;
        mem_is_store     = is_store;
        funct3           = f3;
        Execution_Result = res;
        Mem_addr         = addr;
        store_data       = sdata;
        rd_addr          = rd;
        rd_wr_en         = rwe;
        @(negedge clk);
        exe_valid = 1'b0;
        ok     = is_mem && m_legal(is_store, f3) && m_aligned(f3, addr);
        exp_wr = rwe && (rd != 5'd0);
        if (!is_mem) begin
            check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("alu_wb_exc", {31'd0, wb_exc}, 32'd0);
            check("alu_wb_data", wb_data, res);
            check("alu_wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
            check("alu_wb_wr_en", {31'd0, wb_rd_wr_en}, {31'd0, exp_wr});
            check("alu_stall", {31'd0, mem_stall}, 32'd0);
        end else if (!ok) begin
            check("exc_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("exc_wb_exc", {31'd0, wb_exc}, 32'd1);
            check("exc_wb_data", wb_data, addr);
            check("exc_wb_wr_en", {31'd0, wb_rd_wr_en}, 32'd0);
            check("exc_no_req", {31'd0, dmem_req}, 32'd0);
        end else begin
            check("mem_stall_req", {31'd0, mem_stall}, 32'd1);
            check("mem_req", {31'd0, dmem_req}, 32'd1);
            check("mem_we", {31'd0, dmem_we}, {31'd0, is_store});
            check("mem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("mem_be", {28'd0, dmem_be}, {28'd0, m_be(f3, addr)});
            if (is_store) check("mem_wdata", dmem_wdata, m_wdata(f3, sdata));
            check("mem_no_wb", {31'd0, wb_valid}, 32'd0);
            obs_addr  = dmem_addr;
            obs_be    = dmem_be;
            obs_wdata = dmem_wdata;
            obs_we    = dmem_we;
            for (int i = 0; i < gnt_dly; i++) begin
                system_stall = 1'($urandom_range(0, 1));
                dmem_rvalid  = 1'($urandom_range(0, 1));
                dmem_rdata   = $urandom;
                @(negedge clk);
                check("req_held", {31'd0, dmem_req}, 32'd1);
                check("req_no_wb", {31'd0, wb_valid}, 32'd0);
            end
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            if (is_store) begin
                check("st_wb_valid", {31'd0, wb_valid}, 32'd1);
                check("st_wb_wr_en", {31'd0, wb_rd_wr_en}, 32'd0);
                check("st_wb_exc", {31'd0, wb_exc}, 32'd0);
                check("st_stall", {31'd0, mem_stall}, 32'd0);
                check("st_req_drop", {31'd0, dmem_req}, 32'd0);
            end else begin
                check("ld_wait_stall", {31'd0, mem_stall}, 32'd1);
                check("ld_wait_req", {31'd0, dmem_req}, 32'd0);
                check("ld_wait_wb", {31'd0, wb_valid}, 32'd0);
                for (int i = 0; i < rv_dly; i++) begin
                    system_stall = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check("ld_wait_hold", {31'd0, mem_stall}, 32'd1);
                end
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0;
                check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
                check("ld_wb_data", wb_data, m_load(f3, addr, rdata));
                check("ld_wb_wr_en", {31'd0, wb_rd_wr_en}, {31'd0, exp_wr});
                check("ld_wb_exc", {31'd0, wb_exc}, 32'd0);
                check("ld_wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
                check("ld_stall", {31'd0, mem_stall}, 32'd0);
            end
        end
        system_stall = 1'b0;
    endtask

    // ---------------- table of single-cycle retire vectors ----------------
    typedef struct {
        logic        is_mem;
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        rwe;
        logic        exp_exc;
        logic [31:0] exp_data;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        reset = 1'b1; system_stall = 1'b0; exe_valid = 1'b0; uop_is_mem = 1'b0;
        mem_is_store = 1'b0; funct3 = 3'd0; Execution_Result = '0; Mem_addr = '0;
        store_data = '0; rd_addr = '0; rd_wr_en = 1'b0; dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;

        vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,    5'd5, 1'b1, 1'b0, 32'h1234_5678, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,    5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, 32'h0,    5'd7, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h5555_5555, 32'h3001, 5'd3, 1'b1, 1'b1, 32'h0000_3001, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h5555_5555, 32'h5005, 5'd3, 1'b1, 1'b1, 32'h0000_5005, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h5555_5555, 32'h6003, 5'd3, 1'b1, 1'b1, 32'h0000_6003, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b010, 32'h5555_5555, 32'h7002, 5'd4, 1'b1, 1'b1, 32'h0000_7002, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'b001, 32'h5555_5555, 32'h7001, 5'd4, 1'b1, 1'b1, 32'h0000_7001, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'b100, 32'h5555_5555, 32'h8000, 5'd6, 1'b1, 1'b1, 32'h0000_8000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h5555_5555, 32'h9000, 5'd6, 1'b1, 1'b1, 32'h0000_9000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b110, 32'h5555_5555, 32'hA000, 5'd6, 1'b1, 1'b1, 32'h0000_A000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b111, 32'h5555_5555, 32'hB000, 5'd6, 1'b1, 1'b1, 32'h0000_B000, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'b101, 32'h5555_5555, 32'hC000, 5'd6, 1'b1, 1'b1, 32'h0000_C000, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_exc", {31'd0, wb_exc}, 32'd0);
        check("rst_wb_wr_en", {31'd0, wb_rd_wr_en}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            exe_valid        = 1'b1;
            uop_is_mem       = vecs[i].is_mem;
            mem_is_store     = vecs[i].is_store;
            funct3           = vecs[i].f3;
            Execution_Result = vecs[i].res;
            Mem_addr         = vecs[i].addr;
            store_data       = 32'hFFFF_FFFF;
            rd_addr          = vecs[i].rd;
            rd_wr_en         = vecs[i].rwe;
            @(negedge clk);
            exe_valid = 1'b0;
            check("vec_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("vec_wb_exc", {31'd0, wb_exc}, {31'd0, vecs[i].exp_exc});
            check("vec_wb_data", wb_data, vecs[i].exp_data);
            check("vec_wb_wr_en", {31'd0, wb_rd_wr_en}, {31'd0, vecs[i].exp_wr});
            check("vec_wb_rd", {27'd0, wb_rd_addr}, {27'd0, vecs[i].rd});
            check("vec_no_req", {31'd0, dmem_req}, 32'd0);
            check("vec_stall", {31'd0, mem_stall}, 32'd0);
            @(negedge clk);
            check("vec_pulse_end", {31'd0, wb_valid}, 32'd0);
            check("vec_data_hold", wb_data, vecs[i].exp_data);
        end

        // system_stall blocks acceptance
        @(negedge clk);
        exe_valid = 1'b1; system_stall = 1'b1; uop_is_mem = 1'b1; mem_is_store = 1'b0;
        funct3 = 3'b010; Mem_addr = 32'h100; Execution_Result = 32'h77;
        @(negedge clk);
        exe_valid = 1'b0; system_stall = 1'b0;
        check("sstall_no_req", {31'd0, dmem_req}, 32'd0);
        check("sstall_no_wb", {31'd0, wb_valid}, 32'd0);
        check("sstall_stall", {31'd0, mem_stall}, 32'd0);

        // LB 0x1003, grant after 2 cycles
        do_uop(1'b1, 1'b0, 3'b000, 32'h0, 32'h1003, 32'h0, 5'd9, 1'b1, 2, 1, 32'h80FF_0000);
        check("lb_addr", obs_addr, 32'h0000_1000);
        check("lb_be", {28'd0, obs_be}, 32'h8);
        check("lb_data", wb_data, 32'hFFFF_FF80);

        // SH 0x2002
        do_uop(1'b1, 1'b1, 3'b001, 32'h0, 32'h2002, 32'h0000_ABCD, 5'd10, 1'b1, 1, 0, 32'h0);
        check("sh_be", {28'd0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_we", {31'd0, obs_we}, 32'd1);
        check("sh_wr_en", {31'd0, wb_rd_wr_en}, 32'd0);

        // LHU 0x4002, reset while waiting for read data, then a late rvalid
        @(negedge clk);
        exe_valid = 1'b1; uop_is_mem = 1'b1; mem_is_store = 1'b0; funct3 = 3'b101;
        Mem_addr = 32'h4002; rd_addr = 5'd11; rd_wr_en = 1'b1;
        @(negedge clk);
        exe_valid = 1'b0;
        dmem_gnt  = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rstw_in_wait", {30'd0, state_dbg}, 32'd2);
        reset = 1'b1;
        #1;
        check("rstw_async_stall", {31'd0, mem_stall}, 32'd0);
        check("rstw_async_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_8765;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
        check("rstw_no_req", {31'd0, dmem_req}, 32'd0);
        check("rstw_idle", {30'd0, state_dbg}, 32'd0);
        check("rstw_stall", {31'd0, mem_stall}, 32'd0);

        // Randomized uops against the reference model
        for (int n = 0; n < 60; n++) begin
            bit          r_mem;
            bit          r_st;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            r_mem  = 1'($urandom_range(0, 3) != 0);
            r_st   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) r_f3 = {1'b0, 2'($urandom_range(0, 2))};
            r_addr = $urandom;
            do_uop(r_mem, r_st, r_f3, $urandom, r_addr, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
